reg_file_reader: RTL
====================

// Module: reg_file_reader
// PURPOSE
//  Sequenced read-out engine on the read side of the 16-bit register file.
//  On start it walks a range of register addresses and presents each word
//  on a valid/ready output stream. Data is tagged with its address.
//  Sits between the register file and the debug/trace path; never writes.
// PARAMETERS
//  DATA_W    16  width of one register word
//  NUM_REGS  8   registers in the file (power of two)
//  ADDR_W    3   log2(NUM_REGS)
// PORTS
//  clk          in   1         rising-edge clock
//  rst          in   1         asynchronous, active-low reset
//  start        in   1         begin a read-out sequence (sampled in IDLE only)
//  first_addr   in   ADDR_W    first register address of the sequence
//  count        in   ADDR_W+1  number of words to read (0..NUM_REGS)
//  abort        in   1         cancel the sequence in progress
//  rf_rd_addr   out  ADDR_W    address to register file (registered)
//  rf_rd_data   in   DATA_W    combinational read data for rf_rd_addr
//  out_valid    out  1         out_data/out_addr hold a valid word
//  out_ready    in   1         consumer accepts the word
//  out_data     out  DATA_W    word read
//  out_addr     out  ADDR_W    address the word came from
//  busy         out  1         sequence in progress (state != IDLE)
//  done         out  1         one-cycle pulse: sequence completed
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; all outputs 0; counters 0.
//  - FSM states: IDLE, FETCH, SEND.
//  - IDLE: start=1 and count!=0 -> latch addr=first_addr, remaining=count,
//    go FETCH. start=1 and count==0 -> done=1 next cycle, stay IDLE.
//  - FETCH (1 cycle): rf_rd_addr=addr; at clock edge capture rf_rd_data into
//    out_data, addr into out_addr, set out_valid=1, go SEND.
//  - SEND: out_valid, out_data, out_addr stable until out_valid&out_ready.
//    On handshake: out_valid=0, remaining-=1; remaining was 1 -> done=1,
//    IDLE; else addr=(addr+1) mod NUM_REGS (wraps 7->0), go FETCH.
//  - Throughput: one word per 2 cycles with out_ready held high.
//    First out_valid 2 cycles after start sampled.
//  - start while busy is ignored; first_addr/count sampled only in IDLE.
//  - count==NUM_REGS reads every register once, wrapping as needed.
//  - abort=1 in FETCH/SEND: next edge -> IDLE, out_valid=0, no done pulse.
//    abort has priority over a same-cycle handshake. abort in IDLE: no effect.
//  - done is asserted only in the cycle after the final handshake; busy=0
//    that same cycle.
//  - rf_rd_addr keeps its last value in IDLE.
// CONFIGURATION
//  Macro REG_FILE_READER_PARITY_EN:
//   defined: extra port out_parity (out, 1) = even parity (XOR reduction)
//     of rf_rd_data, captured with out_data in FETCH; 0 on reset; stable in SEND.
//   undefined: port absent; behaviour otherwise identical.
// TESTING
//  1 reset: rst=0 mid-sequence -> all outputs 0 immediately; busy=0 after release.
//  2 rf holds R[i]=16'h1000+i; start, first_addr=2, count=3, out_ready=1
//    -> words 16'h1002/2, 16'h1003/3, 16'h1004/4; done 1 cycle after last.
//  3 first_addr=6, count=4 -> addresses 6,7,0,1 (wrap); data R[6],R[7],R[0],R[1].
//  4 backpressure: out_ready=0 for 5 cycles on first word -> out_valid=1 and
//    out_data=16'h1002 held; no address advance; resumes on out_ready=1.
//  5 count=0 -> busy stays 0, done pulses once, out_valid never asserted.
//  6 abort during SEND of 2nd word of 4 -> IDLE next cycle, out_valid=0,
//    no done; a fresh start then runs normally. With PARITY_EN: 16'h07d8
//    -> out_parity=1, 16'h1245 -> out_parity=1, 16'h0001 -> out_parity=1.

Source files
------------

// File: rtl/reg_file_reader.sv
// reg_file_reader: walks a range of register-file addresses and streams each word, tagged with its address, over valid/ready
//
// Ports:
//   clk, rst (async, active-low)
//   start, first_addr, count : launch a read-out of count words from first_addr (sampled in IDLE only)
//   abort                    : cancel a sequence in progress, no done pulse
//   rf_rd_addr / rf_rd_data  : registered address out, combinational data back from the register file
//   out_valid/out_ready      : output stream handshake carrying out_data and out_addr
//   out_parity               : XOR of the captured word, present only with REG_FILE_READER_PARITY_EN
//   busy                     : a sequence is in progress
//   done                     : one-cycle pulse after the final word is accepted, or after a start with count 0
module reg_file_reader #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
`ifdef REG_FILE_READER_PARITY_EN
  output logic              out_parity,
`endif
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;
  state_t state;
  logic [ADDR_W:0] remaining;
  assign busy = state != IDLE;
  // rf_rd_addr doubles as the walking address, so it holds its last value in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      remaining  <= '0;
      rf_rd_addr <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_addr   <= '0;
      done       <= 1'b0;
`ifdef REG_FILE_READER_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (count != '0) begin
            rf_rd_addr <= first_addr;
            remaining  <= count;
            state      <= FETCH;
          end else done <= 1'b1;
        end
        FETCH: if (abort) state <= IDLE;
        else begin
          out_data  <= rf_rd_data;
          out_addr  <= rf_rd_addr;
          out_valid <= 1'b1;
`ifdef REG_FILE_READER_PARITY_EN
          out_parity <= ^rf_rd_data;
`endif
          state     <= SEND;
        end
        SEND: if (abort) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end else if (out_ready) begin
          out_valid <= 1'b0;
          remaining <= remaining - 1'b1;
          if (remaining == (ADDR_W+1)'(1)) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            rf_rd_addr <= rf_rd_addr + 1'b1;
            state      <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
